mask_unit_read_crossbar_rr: RTL and testbench

Parametrised, registered read-request crossbar for the mask unit: routes NUM_IN read requests to NUM_LANE lane read ports by each request's target lane. Each lane has a round-robin arbiter, replacing fixed lowest-index priority, and a one-entry output register. The winning input's index is forwarded as the write-back index. The block sits between the mask unit's read-request generators and the lane VRF read ports. It is the next-generation, fair, timing-isolated replacement for the combinational crossbar.

---
 rtl/mask_unit_read_crossbar_rr_if.sv | 36 +++
 rtl/mask_unit_read_crossbar_rr.sv | 141 ++++++++++++++
 tb/tb_mask_unit_read_crossbar_rr.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mask_unit_read_crossbar_rr_if.sv
// Bus bundle for the mask-unit read-request crossbar: requester side (in_*) and
// lane VRF read-port side (out_*), flat vectors with slice i at [i*W +: W].
interface mask_unit_read_crossbar_rr_if #(
    parameter int NUM_IN   = 4,
    parameter int NUM_LANE = 4,
    parameter int VS_W     = 5,
    parameter int OFFSET_W = 2,
    parameter int DOFF_W   = 2,
    parameter int LANE_W   = $clog2(NUM_LANE),
    parameter int IDX_W    = $clog2(NUM_IN)
);
    logic [NUM_IN-1:0]          in_valid;
    logic [NUM_IN-1:0]          in_ready;
    logic [NUM_IN*VS_W-1:0]     in_vs;
    logic [NUM_IN*OFFSET_W-1:0] in_offset;
    logic [NUM_IN*LANE_W-1:0]   in_read_lane;
    logic [NUM_IN*DOFF_W-1:0]   in_data_offset;

    logic [NUM_LANE-1:0]          out_valid;
    logic [NUM_LANE-1:0]          out_ready;
    logic [NUM_LANE*VS_W-1:0]     out_vs;
    logic [NUM_LANE*OFFSET_W-1:0] out_offset;
    logic [NUM_LANE*IDX_W-1:0]    out_write_index;
    logic [NUM_LANE*DOFF_W-1:0]   out_data_offset;

    // master: request generators plus lane ports; slave: the crossbar.
    modport master (
        output in_valid, in_vs, in_offset, in_read_lane, in_data_offset, out_ready,
        input  in_ready, out_valid, out_vs, out_offset, out_write_index, out_data_offset
    );

    modport slave (
        input  in_valid, in_vs, in_offset, in_read_lane, in_data_offset, out_ready,
        output in_ready, out_valid, out_vs, out_offset, out_write_index, out_data_offset
    );
endinterface

// File: rtl/mask_unit_read_crossbar_rr.sv
// Registered read-request crossbar: routes NUM_IN requests to NUM_LANE lane ports,
// one round-robin arbiter and one-entry output slot per lane.
module mask_unit_read_crossbar_rr #(
    parameter int NUM_IN   = 4,
    parameter int NUM_LANE = 4,
    parameter int VS_W     = 5,
    parameter int OFFSET_W = 2,
    parameter int DOFF_W   = 2
) (
    input logic                         clock,
    input logic                         reset,
    mask_unit_read_crossbar_rr_if.slave bus
);
    localparam int LANE_W = $clog2(NUM_LANE);
    localparam int IDX_W  = $clog2(NUM_IN);

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef struct packed {
        logic [VS_W-1:0]     vs;
        logic [OFFSET_W-1:0] offset;
        idx_t                idx;
        logic [DOFF_W-1:0]   doff;
    } slot_t;

    // Unpacked request view
    lane_t               in_lane [NUM_IN];
    slot_t               in_req  [NUM_IN];
    logic [NUM_IN-1:0]   req     [NUM_LANE];

    // Arbitration
    logic [NUM_LANE-1:0] grant_vld;
    idx_t                grant_idx [NUM_LANE];
    logic [NUM_LANE-1:0] can_load;
    logic [NUM_LANE-1:0] fire;
    logic [NUM_IN-1:0]   in_ready_w;

    // State
    logic [NUM_LANE-1:0] slot_valid_q, slot_valid_d;
    slot_t               slot_q [NUM_LANE];
    slot_t               slot_d [NUM_LANE];
    idx_t                ptr_q  [NUM_LANE];
    idx_t                ptr_d  [NUM_LANE];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_lane[i]       = bus.in_read_lane[i*LANE_W +: LANE_W];
            in_req[i].vs     = bus.in_vs[i*VS_W +: VS_W];
            in_req[i].offset = bus.in_offset[i*OFFSET_W +: OFFSET_W];
            in_req[i].idx    = idx_t'(i);
            in_req[i].doff   = bus.in_data_offset[i*DOFF_W +: DOFF_W];
        end
        for (int l = 0; l < NUM_LANE; l++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                req[l][i] = bus.in_valid[i] && (in_lane[i] == lane_t'(l));
            end
        end
    end

    // Search starts one past the last winner, so the last winner ends up lowest priority.
    always_comb begin
        int   cand;
        logic found;
        cand = 0;
        for (int l = 0; l < NUM_LANE; l++) begin
            // NOTE: every always_comb output gets a default before any conditional
            // assignment; a path that skips it would infer a latch.
            found        = 1'b0;
            grant_idx[l] = '0;
            for (int k = 1; k <= NUM_IN; k++) begin
                cand = (int'(ptr_q[l]) + k) % NUM_IN;
                if (!found && req[l][cand]) begin
                    found        = 1'b1;
                    grant_idx[l] = idx_t'(cand);
                end
            end
            grant_vld[l] = found;
            can_load[l]  = !slot_valid_q[l] || bus.out_ready[l];
            fire[l]      = found && can_load[l];
        end
    end

    // in_ready looks only at valid, read_lane and lane state, never the data fields.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready_w[i] = bus.in_valid[i]
                         && grant_vld[in_lane[i]]
                         && (grant_idx[in_lane[i]] == idx_t'(i))
                         && can_load[in_lane[i]];
        end
    end

    assign bus.in_ready = in_ready_w;

    always_comb begin
        for (int l = 0; l < NUM_LANE; l++) begin
            slot_valid_d[l] = slot_valid_q[l];
            slot_d[l]       = slot_q[l];
            ptr_d[l]        = ptr_q[l];
            if (fire[l]) begin
                slot_valid_d[l] = 1'b1;
                slot_d[l]       = in_req[grant_idx[l]];
                ptr_d[l]        = grant_idx[l];
            end else if (bus.out_ready[l]) begin
                slot_valid_d[l] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid_q <= '0;
            for (int l = 0; l < NUM_LANE; l++) begin
                // NOTE: the slot data is cleared on reset too (not just the valid bit),
                // so no stale request fields survive a reset onto out_*.
                slot_q[l] <= '0;
                ptr_q[l]  <= idx_t'(NUM_IN - 1);
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so every lane samples
            // pre-edge values regardless of statement order.
            slot_valid_q <= slot_valid_d;
            for (int l = 0; l < NUM_LANE; l++) begin
                slot_q[l] <= slot_d[l];
                ptr_q[l]  <= ptr_d[l];
            end
        end
    end

    always_comb begin
        bus.out_valid = slot_valid_q;
        for (int l = 0; l < NUM_LANE; l++) begin
            bus.out_vs[l*VS_W +: VS_W]               = slot_q[l].vs;
            bus.out_offset[l*OFFSET_W +: OFFSET_W]   = slot_q[l].offset;
            bus.out_write_index[l*IDX_W +: IDX_W]    = slot_q[l].idx;
            bus.out_data_offset[l*DOFF_W +: DOFF_W]  = slot_q[l].doff;
        end
    end

endmodule

// File: tb/tb_mask_unit_read_crossbar_rr.sv
// Directed bench for mask_unit_read_crossbar_rr: expected slot contents are queued per
// lane when a fire is predicted and compared against out_* every cycle.
module tb_mask_unit_read_crossbar_rr;
    localparam int NUM_IN   = 4;
    localparam int NUM_LANE = 4;
    localparam int VS_W     = 5;
    localparam int OFFSET_W = 2;
    localparam int DOFF_W   = 2;
    localparam int LANE_W   = 2;
    localparam int IDX_W    = 2;

    typedef struct packed {
        logic [VS_W-1:0]     vs;
        logic [OFFSET_W-1:0] offset;
        logic [IDX_W-1:0]    idx;
        logic [DOFF_W-1:0]   doff;
    } entry_t;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    entry_t              sb [NUM_LANE][$];
    entry_t              pend [NUM_LANE];
    logic [NUM_LANE-1:0] pend_vld;
    logic [NUM_IN-1:0]   exp_ready;
    logic [LANE_W-1:0]   drv_lane  [NUM_IN];
    entry_t              drv_entry [NUM_IN];

    mask_unit_read_crossbar_rr_if #(
        .NUM_IN(NUM_IN), .NUM_LANE(NUM_LANE), .VS_W(VS_W),
        .OFFSET_W(OFFSET_W), .DOFF_W(DOFF_W)
    ) bus ();

    mask_unit_read_crossbar_rr #(
        .NUM_IN(NUM_IN), .NUM_LANE(NUM_LANE), .VS_W(VS_W),
        .OFFSET_W(OFFSET_W), .DOFF_W(DOFF_W)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int i, input logic [LANE_W-1:0] lane, input logic [VS_W-1:0] vs,
                          input logic [OFFSET_W-1:0] off, input logic [DOFF_W-1:0] doff);
        bus.in_valid[i]                          = 1'b1;
        bus.in_read_lane[i*LANE_W +: LANE_W]     = lane;
        bus.in_vs[i*VS_W +: VS_W]                = vs;
        bus.in_offset[i*OFFSET_W +: OFFSET_W]    = off;
        bus.in_data_offset[i*DOFF_W +: DOFF_W]   = doff;
        drv_lane[i]  = lane;
        drv_entry[i] = '{vs: vs, offset: off, idx: IDX_W'(i), doff: doff};
    endtask

    task automatic clr_all();
        bus.in_valid = '0;
    endtask

    // Declare which inputs must be accepted this cycle; they land in their lane slot.
    task automatic expect_fire(input logic [NUM_IN-1:0] mask);
        exp_ready = mask;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mask[i]) begin
                pend[drv_lane[i]]     = drv_entry[i];
                pend_vld[drv_lane[i]] = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        entry_t obs;
        for (int l = 0; l < NUM_LANE; l++) begin
            obs = '{vs:     bus.out_vs[l*VS_W +: VS_W],
                    offset: bus.out_offset[l*OFFSET_W +: OFFSET_W],
                    idx:    bus.out_write_index[l*IDX_W +: IDX_W],
                    doff:   bus.out_data_offset[l*DOFF_W +: DOFF_W]};
            if (sb[l].size() == 0) begin
                check($sformatf("lane%0d_valid_idle", l), 32'(bus.out_valid[l]), 32'd0);
            end else begin
                check($sformatf("lane%0d_valid", l), 32'(bus.out_valid[l]), 32'd1);
                check($sformatf("lane%0d_fields", l), 32'(obs), 32'(sb[l][0]));
                if (bus.out_ready[l]) void'(sb[l].pop_front());
            end
        end
    endtask

    // Check settled outputs late in the cycle, clock, then commit predicted fires.
    task automatic tick();
        #3;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        compare_outputs();
        @(posedge clk);
        #1;
        for (int l = 0; l < NUM_LANE; l++) begin
            if (pend_vld[l]) sb[l].push_back(pend[l]);
        end
        pend_vld  = '0;
        exp_ready = '0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.in_valid       = '0;
        bus.in_vs          = '0;
        bus.in_offset      = '0;
        bus.in_read_lane   = '0;
        bus.in_data_offset = '0;
        bus.out_ready      = '0;
        pend_vld           = '0;
        exp_ready          = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            drv_lane[i]  = '0;
            drv_entry[i] = '0;
        end
        for (int l = 0; l < NUM_LANE; l++) pend[l] = '0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_vs", 32'(bus.out_vs), 32'd0);
        check("rst_out_write_index", 32'(bus.out_write_index), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request: input 2 -> lane 1
        bus.out_ready = '1;
        set_in(2, 2'd1, 5'h0A, 2'd1, 2'd3);
        expect_fire(4'b0100);
        tick();
        clr_all();
        tick();
        tick();

        // Fairness: all inputs on lane 0, grant order 0,1,2,3,0
        for (int i = 0; i < NUM_IN; i++) set_in(i, 2'd0, VS_W'(5'h10 + i), OFFSET_W'(i), DOFF_W'(3 - i));
        for (int c = 0; c < 5; c++) begin
            expect_fire(4'b0001 << (c % NUM_IN));
            tick();
        end
        clr_all();
        tick();
        tick();

        // Backpressure on lane 3
        bus.out_ready[3] = 1'b0;
        set_in(0, 2'd3, 5'h1F, 2'd3, 2'd2);
        expect_fire(4'b0001);
        tick();
        clr_all();
        set_in(1, 2'd3, 5'h07, 2'd2, 2'd1);
        set_in(2, 2'd3, 5'h15, 2'd1, 2'd0);
        for (int c = 0; c < 5; c++) tick();
        bus.out_ready[3] = 1'b1;
        expect_fire(4'b0010);
        tick();
        bus.in_valid[1] = 1'b0;
        expect_fire(4'b0100);
        tick();
        clr_all();
        tick();
        tick();

        // Parallel lanes: inputs 0..3 -> lanes 3..0
        for (int i = 0; i < NUM_IN; i++) set_in(i, LANE_W'(3 - i), VS_W'(5'h04 + i), OFFSET_W'(i), DOFF_W'(i));
        expect_fire(4'b1111);
        tick();
        clr_all();
        tick();
        tick();

        // Drain and refill on lane 0 without a bubble
        set_in(2, 2'd0, 5'h0C, 2'd0, 2'd1);
        expect_fire(4'b0100);
        tick();
        clr_all();
        set_in(1, 2'd0, 5'h13, 2'd2, 2'd2);
        expect_fire(4'b0010);
        tick();
        clr_all();
        tick();
        tick();

        // Mid-operation reset with all lanes full and stalled
        bus.out_ready = '0;
        for (int i = 0; i < NUM_IN; i++) set_in(i, LANE_W'(i), VS_W'(5'h18 + i), 2'd1, 2'd2);
        expect_fire(4'b1111);
        tick();
        clr_all();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_vs", 32'(bus.out_vs), 32'd0);
        for (int l = 0; l < NUM_LANE; l++) sb[l].delete();
        pend_vld = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = '1;
        set_in(3, 2'd2, 5'h0E, 2'd3, 2'd0);
        set_in(0, 2'd2, 5'h11, 2'd0, 2'd3);
        expect_fire(4'b0001);
        tick();
        bus.in_valid[0] = 1'b0;
        expect_fire(4'b1000);
        tick();
        clr_all();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
